// File: rtl/ttl_pkg.sv
// Shared definitions for the synchronous TTL library models.
// Mode encodings are common to the universal shift register family.
package ttl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl_cen_edge.sv
// Rising-edge detector for the chip clock enable.
// History tracks Cen every cycle; only Reset_n overrides it.
module ttl_cen_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CP,
    input  logic Reset_n,
    input  logic Cen,
    output logic cen_rise
);

    logic last_q;

    always_ff @(posedge CP) begin
        if (!Reset_n) begin
            last_q <= RST_VAL;
        end else begin
            last_q <= Cen;
        end
    end

    assign cen_rise = Cen & ~last_q;

endmodule

// File: rtl/ttl_74299_sync.sv
// 74299 8-bit universal shift/storage register, split-bus synchronous model.
// Advances only on a rising edge of Cen; MR_n clears regardless of Cen.
module ttl_74299_sync
    import ttl_pkg::*;
#(
    parameter int   WIDTH        = 8,
    parameter logic LAST_CEN_RST = 1'b1
) (
    input  logic             CP,
    input  logic             Reset_n,
    input  logic             Cen,
    input  logic             MR_n,
    input  logic             S0,
    input  logic             S1,
    input  logic             DS0,
    input  logic             DS7,
    input  logic             OE1_n,
    input  logic             OE2_n,
    input  logic [WIDTH-1:0] IO_in,
    output logic [WIDTH-1:0] IO_out,
    output logic             IO_oe,
    output logic             Q0s,
    output logic             Q7s
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [1:0]       mode;
    logic             cen_rise;

    assign mode = {S1, S0};

    ttl_cen_edge #(
        .RST_VAL (LAST_CEN_RST)
    ) u_cen_edge (
        .CP       (CP),
        .Reset_n  (Reset_n),
        .Cen      (Cen),
        .cen_rise (cen_rise)
    );

    always_comb begin
        q_d = q_q;
        if (!MR_n) begin
            q_d = '0;
        end else if (cen_rise) begin
            unique case (1'b1)
                (mode == MODE_HOLD): q_d = q_q;
                (mode == MODE_SHR):  q_d = {q_q[WIDTH-2:0], DS0};
                (mode == MODE_SHL):  q_d = {DS7, q_q[WIDTH-1:1]};
                (mode == MODE_LOAD): q_d = IO_in;
                default:             q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (!Reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign IO_out = q_q;
    assign Q0s    = q_q[0];
    assign Q7s    = q_q[WIDTH-1];
    // Never drive the bus while loading from it.
    assign IO_oe  = ~OE1_n & ~OE2_n & ~(S0 & S1);

endmodule

// File: tb/tb_ttl_74299_sync.sv
// Self-checking bench for ttl_74299_sync: directed plan plus random stimulus
// against a behavioural model updated each clock.
module tb_ttl_74299_sync;

    logic       CP = 1'b0;
    logic       Reset_n, Cen, MR_n, S0, S1, DS0, DS7, OE1_n, OE2_n;
    logic [7:0] IO_in;
    logic [7:0] IO_out;
    logic       IO_oe, Q0s, Q7s;

    int compared   = 0;
    int mismatched = 0;
    bit armed      = 1'b0;

    logic [7:0] mq;
    logic       mlast;

    ttl_74299_sync #(
        .WIDTH        (8),
        .LAST_CEN_RST (1'b1)
    ) dut (
        .CP      (CP),
        .Reset_n (Reset_n),
        .Cen     (Cen),
        .MR_n    (MR_n),
        .S0      (S0),
        .S1      (S1),
        .DS0     (DS0),
        .DS7     (DS7),
        .OE1_n   (OE1_n),
        .OE2_n   (OE2_n),
        .IO_in   (IO_in),
        .IO_out  (IO_out),
        .IO_oe   (IO_oe),
        .Q0s     (Q0s),
        .Q7s     (Q7s)
    );

    always #5 CP = ~CP;

    // Reference model: register value as a plain number.
    always @(posedge CP) begin
        int v;
        bit rise;
        if (!Reset_n) begin
            mq    = 8'h00;
            mlast = 1'b1;
        end else begin
            rise  = Cen && !mlast;
            mlast = Cen;
            v     = int'(mq);
            if (!MR_n) begin
                v = 0;
            end else if (rise) begin
                case ({S1, S0})
                    2'b01:   v = (v * 2 + int'(DS0)) % 256;
                    2'b10:   v = v / 2 + 128 * int'(DS7);
                    2'b11:   v = int'(IO_in);
                    default: v = v;
                endcase
            end
            mq = 8'(v);
        end
    end

    always @(negedge CP) begin
        logic exp_oe;
        if (armed) begin
            exp_oe = !OE1_n && !OE2_n && !(S0 && S1);
            compared++;
            if (IO_out !== mq || Q0s !== mq[0] || Q7s !== mq[7]
                || IO_oe !== exp_oe) begin
                mismatched++;
                $display("FAIL cycle_check t=%0t: out=%h q0=%b q7=%b oe=%b required out=%h q0=%b q7=%b oe=%b",
                         $time, IO_out, Q0s, Q7s, IO_oe, mq, mq[0], mq[7], exp_oe);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic chkq(input string name, input logic [7:0] exp);
        chk({name, "_dut"}, IO_out, exp);
        chk({name, "_model"}, mq, exp);
    endtask

    task automatic pulse();
        Cen = 1'b0;
        tick(1);
        Cen = 1'b1;
        tick(1);
        Cen = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        S1 = 1'b1; S0 = 1'b1; IO_in = v;
        pulse();
    endtask

    initial begin
        Reset_n = 1'b0; Cen = 1'b0; MR_n = 1'b1;
        S0 = 1'b0; S1 = 1'b0; DS0 = 1'b0; DS7 = 1'b0;
        OE1_n = 1'b0; OE2_n = 1'b0; IO_in = 8'h00;
        tick(2);
        armed = 1'b1;
        chkq("reset_q", 8'h00);
        chk("reset_q0", {7'd0, Q0s}, 8'h00);
        chk("reset_q7", {7'd0, Q7s}, 8'h00);
        Reset_n = 1'b1;
        tick(1);

        load(8'hA5);
        chkq("load_a5", 8'hA5);
        chk("load_oe", {7'd0, IO_oe}, 8'h00);
        chk("load_q0", {7'd0, Q0s}, 8'h01);
        chk("load_q7", {7'd0, Q7s}, 8'h01);

        S1 = 1'b0; S0 = 1'b1; DS0 = 1'b0;
        repeat (3) pulse();
        chkq("shr3", 8'h28);
        chk("shr3_q7", {7'd0, Q7s}, 8'h00);
        DS0 = 1'b1;
        pulse();
        chkq("shr_ds1", 8'h51);

        load(8'h81);
        S1 = 1'b1; S0 = 1'b0; DS7 = 1'b1;
        Cen = 1'b0;
        tick(1);
        Cen = 1'b1;
        tick(1);
        chkq("shl1", 8'hC0);
        chk("shl1_q0", {7'd0, Q0s}, 8'h00);
        tick(4);
        chkq("shl_held", 8'hC0);
        Cen = 1'b0;

        load(8'hFF);
        IO_in = 8'h3C;
        tick(1);
        Cen = 1'b1; MR_n = 1'b0;
        tick(1);
        chkq("mr_clear", 8'h00);
        MR_n = 1'b1;
        tick(3);
        chkq("mr_no_defer", 8'h00);
        Cen = 1'b0;
        tick(1);
        Cen = 1'b1;
        tick(1);
        chkq("mr_then_load", 8'h3C);
        Cen = 1'b0;

        load(8'h5A);
        S1 = 1'b0; S0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OE1_n = i[0]; OE2_n = i[1];
            tick(1);
            chk($sformatf("oe_sweep%0d", i), {7'd0, IO_oe},
                (i == 0) ? 8'h01 : 8'h00);
            chkq("oe_hold", 8'h5A);
        end
        OE1_n = 1'b0; OE2_n = 1'b0; S1 = 1'b1; S0 = 1'b1;
        tick(1);
        chk("oe_load_mode", {7'd0, IO_oe}, 8'h00);
        chkq("oe_load_hold", 8'h5A);

        Cen = 1'b1; Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1; S1 = 1'b0; S0 = 1'b1; DS0 = 1'b1;
        tick(3);
        chkq("rst_cen_high", 8'h00);
        Cen = 1'b0;
        tick(1);
        Cen = 1'b1;
        tick(1);
        chkq("rst_then_shr", 8'h01);

        for (int i = 0; i < 600; i++) begin
            Reset_n = ($urandom_range(0, 49) != 0);
            MR_n    = ($urandom_range(0, 19) != 0);
            Cen     = 1'($urandom);
            S0      = 1'($urandom);
            S1      = 1'($urandom);
            DS0     = 1'($urandom);
            DS7     = 1'($urandom);
            OE1_n   = 1'($urandom);
            OE2_n   = 1'($urandom);
            IO_in   = 8'($urandom);
            tick(1);
        end
        Reset_n = 1'b1; MR_n = 1'b1;
        tick(2);
        armed = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
